mem_image_loader: RTL and testbench

Synthesizable, parametrised memory image engine for the 6502 system memory. It streams a program image into memory (LOAD), fills a range with a constant (FILL), or reads a range back and compares it against a reference stream (VERIFY). While active it holds the CPU via `cpu_hold`. It replaces testbench-only memory override paths with a real write port into `mem`, so benches and future boot logic share one preload mechanism.

---
 rtl/mem_image_loader.sv | 124 ++++++++++++
 tb/tb_mem_image_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_image_loader.sv
// mem_image_loader: streams LOAD/FILL/VERIFY operations into system memory while holding the CPU
module mem_image_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [1:0] M_FILL = 2'b01, M_VERIFY = 2'b10, M_ILLEGAL = 2'b11;

    state_t                state, state_nx;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q, offset_q, cmp_addr;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [DATA_WIDTH-1:0] fill_q, exp_q, cmp_exp;
    logic                  cmp_v, rem_nz, active, issue, mismatch;

    always_comb begin
        rem_nz   = |remaining_q;
        active   = state == RUN || state == DRAIN;
        issue    = state == RUN && rem_nz && !abort && (mode_q == M_FILL || src_valid);
        mismatch = cmp_v && !abort && mem_rdata != cmp_exp;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // RUN exits once the last strobe is on the port; VERIFY then waits one cycle for its read data
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start && mode != M_ILLEGAL ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : rem_nz ? RUN : mode_q == M_VERIFY ? DRAIN : DONE;
            DRAIN:   state_nx = abort ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = active;
        cpu_hold  = active;
        done      = state == DONE;
        src_ready = state == RUN && rem_nz && !abort && mode_q != M_FILL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q              <= '0;
            base_q              <= '0;
            offset_q            <= '0;
            remaining_q         <= '0;
            fill_q              <= '0;
            exp_q               <= '0;
            cmp_exp             <= '0;
            cmp_addr            <= '0;
            cmp_v               <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_we              <= 1'b0;
            mem_re              <= 1'b0;
            error               <= 1'b0;
            mismatch_count      <= '0;
            first_mismatch_addr <= '0;
        end else begin
            mem_we   <= issue && mode_q != M_VERIFY;
            mem_re   <= issue && mode_q == M_VERIFY;
            cmp_v    <= mem_re && !abort;
            cmp_exp  <= exp_q;
            cmp_addr <= mem_addr;
            if (issue) begin
                mem_addr    <= base_q + offset_q;
                mem_wdata   <= mode_q == M_FILL ? fill_q : src_data;
                exp_q       <= src_data;
                offset_q    <= offset_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (state == IDLE && start) begin
                mode_q              <= mode;
                base_q              <= base_addr;
                fill_q              <= fill_value;
                offset_q            <= '0;
                remaining_q         <= length;
                error               <= mode == M_ILLEGAL;
                mismatch_count      <= '0;
                first_mismatch_addr <= '0;
            end else if (active && abort) begin
                error <= 1'b1;
            end
            if (mismatch) begin
                if (mismatch_count == '0)
                    first_mismatch_addr <= cmp_addr;
                if (~&mismatch_count)
                    mismatch_count <= mismatch_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: directed and randomized checks of mem_image_loader against a memory-level model
module tb_mem_image_loader;
    localparam logic [1:0] LOAD = 2'b00, FILL = 2'b01, VERIFY = 2'b10, ILL = 2'b11;

    logic        clk = 1'b0;
    logic        reset, start, abort, src_valid, src_ready, mem_we, mem_re;
    logic        cpu_hold, busy, done, error;
    logic [1:0]  mode;
    logic [15:0] base_addr, mem_addr, mismatch_count, first_mismatch_addr;
    logic [16:0] length;
    logic [7:0]  fill_value, src_data, mem_wdata, mem_rdata;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  stream  [$];
    int n_asrt = 0, n_fail = 0;
    int n_we = 0, n_re = 0, n_done = 0;
    int d_we, d_re, d_done, abort_k;

    always #5 clk = ~clk;

    mem_image_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .base_addr(base_addr), .length(length), .fill_value(fill_value),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .mismatch_count(mismatch_count), .first_mismatch_addr(first_mismatch_addr)
    );

    // synchronous-read memory: data for a read strobe appears the cycle after it
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        if (mem_re === 1'b1) mem_rdata <= mem[mem_addr];
        n_we   <= n_we + int'(mem_we === 1'b1);
        n_re   <= n_re + int'(mem_re === 1'b1);
        n_done <= n_done + int'(done === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int region_bad(input logic [15:0] b, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (mem[16'(b + i)] !== ref_mem[16'(b + i)]) bad++;
        return bad;
    endfunction

    task automatic ref_load(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) ref_mem[16'(b + i)] = stream[i];
    endtask

    task automatic ref_fill(input logic [15:0] b, input int n, input logic [7:0] f);
        for (int i = 0; i < n; i++) ref_mem[16'(b + i)] = f;
    endtask

    task automatic model_verify(input logic [15:0] b, input int n, output int cnt, output logic [15:0] first);
        cnt = 0;
        first = '0;
        for (int i = 0; i < n; i++)
            if (stream[i] != ref_mem[16'(b + i)]) begin
                if (cnt == 0) first = 16'(b + i);
                cnt++;
            end
    endtask

    // stall < 0 toggles src_valid every cycle; cyc is start edge to done edge, -1 if no done
    task automatic op(input logic [1:0] m, input logic [15:0] b, input int n, input logic [7:0] f,
                      input int stall, input int abort_at, input int rst_at, input int bstart_at,
                      output int cyc, output int acc, output int bk);
        int we0, re0, dn0;
        logic hold_bad;
        @(negedge clk);
        we0 = n_we; re0 = n_re; dn0 = n_done;
        mode = m; base_addr = b; length = 17'(n); fill_value = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = -1; acc = 0; bk = 0; hold_bad = 1'b0; abort_k = -1;
        while (bk < 400) begin
            if (done === 1'b1) begin
                cyc = bk + 1;
                chk("busy_low_with_done", {busy, cpu_hold}, 2'b00);
                break;
            end
            if (busy !== 1'b1) break;
            if (cpu_hold !== busy) hold_bad = 1'b1;
            start = bk == bstart_at;
            if (start) begin mode = FILL; base_addr = ~b; length = 17'd1; end
            abort = acc == abort_at;
            if (abort && abort_k < 0) abort_k = bk;
            reset = acc == rst_at;
            src_valid = acc < stream.size() && (stall < 0 ? bk % 2 == 0 : $urandom_range(99) >= stall);
            src_data = src_valid ? stream[acc] : 8'($urandom);
            #1;
            if (src_valid && src_ready) acc++;
            @(negedge clk);
            bk++;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0; src_valid = 1'b0;
        chk("op_bounded", bk < 400, 1'b1);
        chk("cpu_hold_tracks_busy", hold_bad, 1'b0);
        repeat (2) @(negedge clk);
        d_we = n_we - we0; d_re = n_re - re0; d_done = n_done - dn0;
    endtask

    initial begin
        int cyc, acc, bk, ec;
        logic [15:0] ef, b;
        logic [7:0] v;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = LOAD; base_addr = '0; length = '0;
        fill_value = '0; src_valid = 1'b0; src_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cpu_hold", cpu_hold, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_src_ready", src_ready, 1'b0);
        chk("rst_strobes", {mem_we, mem_re}, 2'b00);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h0);
        chk("rst_mismatch_count", mismatch_count, 16'h0);
        chk("rst_first_mismatch", first_mismatch_addr, 16'h0);
        reset = 1'b0;

        stream.delete();
        for (int i = 0; i < 16; i++) stream.push_back(8'(i));
        op(LOAD, 16'h0200, 16, 8'h00, -1, -1, -1, -1, cyc, acc, bk);
        ref_load(16'h0200, 16);
        chk("load_writes", d_we, 16);
        chk("load_done_pulses", d_done, 1);
        chk("load_done_seen", cyc > 0, 1'b1);
        chk("load_mem", region_bad(16'h0200, 16), 0);
        chk("load_error", error, 1'b0);

        stream.delete();
        op(FILL, 16'hFFFE, 4, 8'hEA, 0, -1, -1, -1, cyc, acc, bk);
        ref_fill(16'hFFFE, 4, 8'hEA);
        chk("fill_latency", cyc, 6);
        chk("fill_writes", d_we, 4);
        chk("fill_done_pulses", d_done, 1);
        chk("fill_wrap_mem", region_bad(16'hFFFE, 4), 0);

        b = 16'($urandom);
        stream.delete();
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            if (i == 3 && v == 8'h55) v = 8'h56;
            if (i == 6 && v == 8'hAA) v = 8'hAB;
            stream.push_back(v);
        end
        op(LOAD, b, 8, 8'h00, 0, -1, -1, -1, cyc, acc, bk);
        ref_load(b, 8);
        chk("vload_latency", cyc, 10);
        stream[3] = 8'h55;
        stream[6] = 8'hAA;
        model_verify(b, 8, ec, ef);
        op(VERIFY, b, 8, 8'h00, 0, -1, -1, -1, cyc, acc, bk);
        chk("verify_latency", cyc, 11);
        chk("verify_reads", d_re, 8);
        chk("verify_no_writes", d_we, 0);
        chk("verify_mismatch_count", mismatch_count, 16'(ec));
        chk("verify_first_addr", first_mismatch_addr, ef);
        chk("verify_done_pulses", d_done, 1);
        chk("verify_error", error, 1'b0);

        stream.delete();
        op(FILL, 16'h1234, 0, 8'h77, 0, -1, -1, -1, cyc, acc, bk);
        chk("len0_latency", cyc, 2);
        chk("len0_no_strobes", d_we + d_re, 0);
        chk("len0_done_pulses", d_done, 1);

        op(ILL, 16'h1000, 5, 8'h00, 0, -1, -1, -1, cyc, acc, bk);
        chk("illegal_error", error, 1'b1);
        chk("illegal_no_done", d_done, 0);
        chk("illegal_busy_short", bk <= 1, 1'b1);
        chk("illegal_no_strobes", d_we + d_re, 0);

        stream.delete();
        for (int i = 0; i < 10; i++) stream.push_back(8'($urandom));
        op(LOAD, 16'h3000, 10, 8'h00, 0, 5, -1, -1, cyc, acc, bk);
        ref_load(16'h3000, 5);
        chk("abort_error", error, 1'b1);
        chk("abort_no_done", d_done, 0);
        chk("abort_writes", d_we, 5);
        chk("abort_busy_falls_next", bk, abort_k + 1);
        chk("abort_mem", region_bad(16'h3000, 5), 0);
        stream.delete();
        op(FILL, 16'h4000, 3, 8'h5A, 0, -1, -1, -1, cyc, acc, bk);
        ref_fill(16'h4000, 3, 8'h5A);
        chk("restart_clears_error", error, 1'b0);
        chk("restart_done", d_done, 1);
        chk("restart_mem", region_bad(16'h4000, 3), 0);

        stream.delete();
        for (int i = 0; i < 8; i++) stream.push_back(ref_mem[16'(b + i)]);
        op(VERIFY, b, 8, 8'h00, 0, -1, 3, -1, cyc, acc, bk);
        chk("reset_mid_outputs", {busy, cpu_hold, done, error, src_ready, mem_we, mem_re,
                                  mem_addr, mem_wdata, mismatch_count, first_mismatch_addr}, 64'h0);
        chk("reset_mid_no_done", d_done, 0);
        op(VERIFY, b, 8, 8'h00, 30, -1, -1, 2, cyc, acc, bk);
        chk("post_reset_verify_done", d_done, 1);
        chk("post_reset_verify_reads", d_re, 8);
        chk("busy_start_ignored", d_we, 0);
        chk("post_reset_verify_clean", mismatch_count, 16'h0);

        for (int it = 0; it < 6; it++) begin
            int n;
            b = it % 2 == 0 ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
            n = $urandom_range(24, 1);
            stream.delete();
            for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
            op(LOAD, b, n, 8'h00, 40, -1, -1, -1, cyc, acc, bk);
            ref_load(b, n);
            chk("rnd_load_writes", d_we, n);
            chk("rnd_load_mem", region_bad(b, n), 0);
            for (int i = 0; i < n; i++)
                if ($urandom_range(3) == 0) stream[i] = stream[i] ^ 8'($urandom_range(255, 1));
            model_verify(b, n, ec, ef);
            op(VERIFY, b, n, 8'h00, 40, -1, -1, -1, cyc, acc, bk);
            chk("rnd_verify_count", mismatch_count, 16'(ec));
            chk("rnd_verify_first", first_mismatch_addr, ef);
            chk("rnd_verify_done", {d_done, d_re}, {32'd1, 32'(n)});
            v = 8'($urandom);
            stream.delete();
            op(FILL, b, n, v, 0, -1, -1, -1, cyc, acc, bk);
            ref_fill(b, n, v);
            chk("rnd_fill_latency", cyc, n + 2);
            chk("rnd_fill_mem", region_bad(b, n), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
